// File: rtl/sdiv_pow2_pkg.sv
// Shared types and helpers for the power-of-two signed divider pipeline.
// The stage-1 payload is sized by DIV_N, so the top must be built with N == DIV_N.
package sdiv_pow2_pkg;

  localparam int DIV_N  = 8;
  localparam int DIV_SW = $clog2(DIV_N);

  typedef struct packed {
    logic [DIV_N-1:0]  biased;
    logic [DIV_N-1:0]  dividend;
    logic [DIV_SW-1:0] shift;
  } s1_payload_t;

  // Shift amounts past the top bit behave like a full-width shift.
  function automatic logic [DIV_SW-1:0] clamp_shift(input logic [DIV_SW-1:0] shift);
    logic [DIV_SW-1:0] result;
    if (32'(shift) > 32'(DIV_N - 1)) begin
      result = DIV_SW'(DIV_N - 1);
    end else begin
      result = shift;
    end
    return result;
  endfunction

endpackage

// File: rtl/sdiv_pow2_pipe_asr.sv
// Combinational variable arithmetic right shift built as one mux per output bit.
module asr_var #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  din,
  input  logic [SW-1:0] shift,
  output logic [N-1:0]  dout
);

  // Bit i takes din[i+shift], or the sign bit once that index runs off the top.
  always_comb begin
    logic [SW:0] idx;
    idx  = {(SW+1){1'b0}};
    dout = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx = (SW+1)'(i) + {1'b0, shift};
      if (idx <= (SW+1)'(N - 1)) begin
        dout[i] = din[idx[SW-1:0]];
      end else begin
        dout[i] = din[N-1];
      end
    end
  end

endmodule

// File: rtl/sdiv_pow2_pipe.sv
// Two-stage signed divide by 2^s with floor or truncating rounding, quotient and remainder,
// and valid/ready handshakes on both sides.
module sdiv_pow2_pipe
  import sdiv_pow2_pkg::*;
#(
  parameter int N  = DIV_N,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shift,
  input  logic          up_trunc,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_quot,
  output logic [N-1:0]  down_rem
);

  logic          v1_r;
  logic          v2_r;
  logic          ready1_s;
  logic          ready2_s;
  logic          load1_s;
  logic          load2_s;
  logic [SW-1:0] shift_s;
  logic [N-1:0]  bias_s;
  s1_payload_t   d1_next_s;
  s1_payload_t   d1_r;
  logic [N-1:0]  quot_s;
  logic [N-1:0]  rem_s;
  logic [N-1:0]  quot_r;
  logic [N-1:0]  rem_r;

  // Ready chain: the only combinational path runs from down_ready to up_ready.
  always_comb begin
    ready2_s = !v2_r || down_ready;
    ready1_s = !v1_r || ready2_s;
    load1_s  = up_valid && ready1_s;
    load2_s  = v1_r && ready2_s;
  end

  // Truncating mode pre-biases negative dividends by 2^s-1 so the floor shift rounds toward zero.
  always_comb begin
    shift_s = clamp_shift(up_shift);
    if (up_trunc && up_data[N-1]) begin
      bias_s = ~({N{1'b1}} << shift_s);
    end else begin
      bias_s = {N{1'b0}};
    end
    d1_next_s.biased   = up_data + bias_s;
    d1_next_s.dividend = up_data;
    d1_next_s.shift    = shift_s;
  end

  asr_var #(.N(N), .SW(SW)) u_asr (
    .din   (d1_r.biased),
    .shift (d1_r.shift),
    .dout  (quot_s)
  );

  // The remainder is whatever the quotient leaves behind, modulo 2^N.
  always_comb begin
    rem_s = d1_r.dividend - (quot_s << d1_r.shift);
  end

  // Stage valid flags; reset discards any in-flight beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
    end else begin
      if (ready1_s) begin
        v1_r <= up_valid;
      end
      if (ready2_s) begin
        v2_r <= v1_r;
      end
    end
  end

  // Payload registers need no reset: their contents are ignored while the stage is empty.
  always_ff @(posedge clk) begin
    if (load1_s) begin
      d1_r <= d1_next_s;
    end
    if (load2_s) begin
      quot_r <= quot_s;
      rem_r  <= rem_s;
    end
  end

  assign up_ready   = ready1_s;
  assign down_valid = v2_r;
  assign down_quot  = quot_r;
  assign down_rem   = rem_r;

endmodule

// File: tb/tb_sdiv_pow2_pipe.sv
// Directed and random bench for sdiv_pow2_pipe with a reference-model scoreboard.
module tb_sdiv_pow2_pipe;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shift;
  logic          up_trunc;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_quot;
  logic [N-1:0]  down_rem;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic       t;
    logic [7:0] q;
    logic [7:0] r;
  } exp_t;

  exp_t sb_q[$];

  sdiv_pow2_pipe #(.N(N), .SW(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_shift   (up_shift),
    .up_trunc   (up_trunc),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_quot  (down_quot),
    .down_rem   (down_rem)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Integer reference: truncating uses SV division, floor adjusts by a non-negative modulus.
  function automatic exp_t model(input logic [7:0] d, input logic [2:0] s, input logic t);
    exp_t e;
    int   di, p, m, qi;
    di = int'($signed(d));
    p  = 1 << s;
    if (t) begin
      qi = di / p;
    end else begin
      m = di % p;
      if (m < 0) m = m + p;
      qi = (di - m) / p;
    end
    e.d = d; e.s = s; e.t = t;
    e.q = 8'(qi);
    e.r = 8'(di - qi * p);
    return e;
  endfunction

  // Scoreboard and output-hold monitor, sampled on the falling edge.
  initial begin
    exp_t       e;
    logic       stall = 1'b0;
    logic [7:0] stall_q, stall_r, ident;
    int         ri, di, p;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        stall = 1'b0;
      end else begin
        if (stall) begin
          check_eq("hold_valid", 32'(down_valid), 32'd1);
          check_eq("hold_quot", 32'(down_quot), 32'(stall_q));
          check_eq("hold_rem", 32'(down_rem), 32'(stall_r));
        end
        if (up_valid && up_ready) sb_q.push_back(model(up_data, up_shift, up_trunc));
        if (down_valid && down_ready) begin
          if (sb_q.size() == 0) begin
            check_eq("sb_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check_eq("sb_quot", 32'(down_quot), 32'(e.q));
            check_eq("sb_rem", 32'(down_rem), 32'(e.r));
            ident = (down_quot << e.s) + down_rem;
            check_eq("sb_identity", 32'(ident), 32'(e.d));
            ri = int'($signed(down_rem));
            di = int'($signed(e.d));
            p  = 1 << e.s;
            if (!e.t) begin
              check_eq("sb_floor_rem_range", 32'(ri >= 0 && ri < p), 32'd1);
            end else begin
              check_eq("sb_trunc_rem_rule",
                       32'(ri > -p && ri < p && (ri == 0 || ((ri < 0) == (di < 0)))), 32'd1);
            end
          end
        end
        stall   = down_valid && !down_ready;
        stall_q = down_quot;
        stall_r = down_rem;
      end
    end
  end

  task automatic one_beat(input string tag, input logic [7:0] d, input logic [2:0] s,
                          input logic t, input logic [7:0] eq, input logic [7:0] er);
    @(posedge clk); #1;
    down_ready = 1'b1;
    up_valid = 1'b1; up_data = d; up_shift = s; up_trunc = t;
    @(negedge clk);
    check_eq({tag, "_accept"}, 32'(up_ready), 32'd1);
    @(posedge clk); #1;
    up_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_lat1"}, 32'(down_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(down_valid), 32'd1);
    check_eq({tag, "_quot"}, 32'(down_quot), 32'(eq));
    check_eq({tag, "_rem"}, 32'(down_rem), 32'(er));
    @(negedge clk);
    check_eq({tag, "_nodup"}, 32'(down_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] beats [5];
    int idx, outs, sent;
    logic fired;

    rst_n = 1'b0; up_valid = 1'b0; down_ready = 1'b0;
    up_data = 8'h00; up_shift = 3'd0; up_trunc = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_down_valid", 32'(down_valid), 32'd0);
    check_eq("reset_up_ready", 32'(up_ready), 32'd1);

    one_beat("floor_m7_s1", 8'hF9, 3'd1, 1'b0, 8'hFC, 8'h01);
    one_beat("trunc_m7_s1", 8'hF9, 3'd1, 1'b1, 8'hFD, 8'hFF);
    one_beat("pos_floor",   8'h7F, 3'd3, 1'b0, 8'h0F, 8'h07);
    one_beat("pos_trunc",   8'h7F, 3'd3, 1'b1, 8'h0F, 8'h07);
    one_beat("min_trunc",   8'h80, 3'd7, 1'b1, 8'hFF, 8'h00);
    one_beat("min_floor",   8'h80, 3'd7, 1'b0, 8'hFF, 8'h00);
    one_beat("s0_trunc",    8'h5A, 3'd0, 1'b1, 8'h5A, 8'h00);
    one_beat("s0_floor",    8'hA5, 3'd0, 1'b0, 8'hA5, 8'h00);
    one_beat("m127_trunc",  8'h81, 3'd7, 1'b1, 8'h00, 8'h81);
    one_beat("m127_floor",  8'h81, 3'd7, 1'b0, 8'hFF, 8'h01);

    // Backpressure: two beats fill the pipe, then down_ready rises with a beat waiting.
    beats = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    idx = 0; outs = 0;
    for (int cyc = 0; cyc < 40 && outs < 5; cyc++) begin
      @(posedge clk); #1;
      down_ready = (cyc >= 4);
      up_valid   = (idx < 5);
      if (idx < 5) up_data = beats[idx];
      up_shift = 3'd4; up_trunc = 1'b0;
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        check_eq("bp_up_ready_low", 32'(up_ready), 32'd0);
        check_eq("bp_held_quot", 32'(down_quot), 32'h01);
      end
      if (up_valid && up_ready) idx++;
      if (down_valid && down_ready) begin
        check_eq("bp_quot", 32'(down_quot), 32'(outs + 1));
        check_eq("bp_rem", 32'(down_rem), 32'd0);
        check_eq("bp_no_gap", 32'(cyc), 32'(4 + outs));
        outs++;
      end
    end
    @(posedge clk); #1 up_valid = 1'b0;
    check_eq("bp_count", 32'(outs), 32'd5);

    // Random traffic; the monitor checks every result against the model.
    sent = 0; fired = 1'b0;
    for (int cyc = 0; cyc < 60000 && !(sent == 10000 && sb_q.size() == 0); cyc++) begin
      @(posedge clk); #1;
      if (fired) up_valid = 1'b0;
      if (!up_valid && sent < 10000 && $urandom_range(0, 3) != 0) begin
        up_valid = 1'b1;
        up_data  = 8'($urandom);
        up_shift = 3'($urandom_range(0, 7));
        up_trunc = 1'($urandom_range(0, 1));
      end
      down_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      fired = up_valid && up_ready;
      if (fired) sent++;
    end
    @(posedge clk); #1 up_valid = 1'b0; down_ready = 1'b1;
    check_eq("rand_sent", 32'(sent), 32'd10000);
    check_eq("rand_drained", 32'(sb_q.size()), 32'd0);

    // Reset while both stages hold stalled beats.
    @(posedge clk); #1;
    down_ready = 1'b0;
    up_valid = 1'b1; up_data = 8'h33; up_shift = 3'd1; up_trunc = 1'b0;
    @(posedge clk); #1 up_data = 8'h44;
    @(posedge clk); #1 up_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_full_up_ready", 32'(up_ready), 32'd0);
    check_eq("rst_full_down_valid", 32'(down_valid), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_down_valid", 32'(down_valid), 32'd0);
    check_eq("rst_mid_up_ready", 32'(up_ready), 32'd1);
    one_beat("after_rst", 8'hF0, 3'd2, 1'b1, 8'hFC, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
